puf_challenge_sequencer: RTL

Challenge-side driver for the arbiter-PUF array. It generates a sequence of 8-bit challenges from an LFSR and drives each one, with a race pulse, into the PUF delay lines. It then captures the 7-bit asynchronous response and emits each {challenge, response} pair on a valid/ready stream, for enrollment readout or on-chip authentication. It sits between the top-level IO wrapper and the `arbiterpuf` instance, and replaces the direct `clk`→`ipulse` / `uio_in`→`ichallenge` wiring.

---
 rtl/puf_pkg.sv | 12 +
 rtl/puf_resp_sync.sv | 20 ++
 rtl/puf_challenge_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding, LFSR constants and defaults for the PUF challenge sequencer
package puf_pkg;
    typedef enum logic [2:0] {IDLE, APPLY, FIRE, CAPTURE, EMIT, DONE} state_t;
    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;
    localparam int C_LENGTH_DEF = 8;
    localparam int R_WIDTH_DEF = 7;
    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 8'h01;
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] c);
        return {c[LFSR_W-2:0], ^(c & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/puf_resp_sync.sv
// puf_resp_sync: two-flop synchronizer for the asynchronous PUF response bus
module puf_resp_sync #(
    parameter int R_WIDTH = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [R_WIDTH-1:0] d,
    output logic [R_WIDTH-1:0] q
);
    logic [R_WIDTH-1:0] meta;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer: LFSR challenge driver and response capture for the arbiter PUF; optional PUF_MAJORITY_VOTE_EN
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int C_LENGTH      = C_LENGTH_DEF,
    parameter int R_WIDTH       = R_WIDTH_DEF,
    parameter int SETTLE_CYCLES = 4,
    parameter int PULSE_CYCLES  = 2,
    parameter int VOTE_COUNT    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          seed,
    input  logic [7:0]          count,
    output logic [C_LENGTH-1:0] ichallenge,
    output logic                ipulse,
    input  logic [R_WIDTH-1:0]  oresponse,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_challenge,
    output logic [R_WIDTH-1:0]  out_response,
    output logic                busy,
    output logic                done
);
    if (SETTLE_CYCLES < 1 || PULSE_CYCLES < 1 || VOTE_COUNT % 2 == 0 || VOTE_COUNT > 15) begin : g_bad_params
        $error("puf_challenge_sequencer: illegal parameter combination");
    end

    state_t state, state_nx;
    logic [7:0] phase;
    logic last_phase, last_rep;
    logic [8:0] remaining;
    logic [LFSR_W-1:0] lfsr;
    logic [R_WIDTH-1:0] resp, resp_sync, resp_next;

    puf_resp_sync #(.R_WIDTH(R_WIDTH)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (oresponse),
        .q    (resp_sync)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        last_phase = (state == APPLY) ? phase == 8'(SETTLE_CYCLES - 1) :
                     (state == FIRE)  ? phase == 8'(PULSE_CYCLES - 1)  : phase == 8'd2;
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? APPLY : IDLE;
            APPLY:   state_nx = last_phase ? FIRE : APPLY;
            FIRE:    state_nx = last_phase ? CAPTURE : FIRE;
            CAPTURE: state_nx = !last_phase ? CAPTURE : last_rep ? EMIT : APPLY;
            EMIT:    state_nx = !out_ready ? EMIT : (remaining == 9'd1) ? DONE : APPLY;
            default: state_nx = IDLE;
        endcase
    end

    assign ichallenge    = C_LENGTH'(lfsr);
    assign ipulse        = state == FIRE;
    assign out_valid     = state == EMIT;
    assign out_challenge = lfsr;
    assign out_response  = resp;
    assign busy          = state inside {APPLY, FIRE, CAPTURE, EMIT};
    assign done          = state == DONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase     <= '0;
            remaining <= '0;
            lfsr      <= '0;
            resp      <= '0;
        end else begin
            phase <= (state_nx != state) ? 8'd0 : phase + 8'd1;
            if (state == IDLE && start) begin
                lfsr      <= (seed == 8'h00) ? ZERO_SEED_SUB : seed;
                remaining <= (count == 8'h00) ? 9'd256 : {1'b0, count};
            end
            if (state == EMIT && out_ready) begin
                remaining <= remaining - 9'd1;
                if (remaining != 9'd1) lfsr <= lfsr_step(lfsr);
            end
            if (state == CAPTURE && last_phase && last_rep) resp <= resp_next;
        end
    end

`ifdef PUF_MAJORITY_VOTE_EN
    logic [3:0] rep;
    logic [3:0] acc [R_WIDTH];
    assign last_rep = rep == 4'(VOTE_COUNT - 1);
    // The final repetition's bit is folded in directly rather than waiting a cycle
    always_comb begin
        resp_next = '0;
        for (int i = 0; i < R_WIDTH; i++)
            resp_next[i] = (acc[i] + 4'(resp_sync[i])) > 4'(VOTE_COUNT / 2);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep <= '0;
            for (int i = 0; i < R_WIDTH; i++) acc[i] <= '0;
        end else if (state == CAPTURE && last_phase) begin
            rep <= last_rep ? 4'd0 : rep + 4'd1;
            for (int i = 0; i < R_WIDTH; i++) acc[i] <= last_rep ? 4'd0 : acc[i] + 4'(resp_sync[i]);
        end
    end
`else
    assign last_rep  = 1'b1;
    assign resp_next = resp_sync;
`endif
endmodule
